// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS32 fetch PC with prioritised redirects and stall-time redirect buffering.
// Optional PC_ALIGN_CHECK_EN: flags misaligned redirect targets and clears their low two bits.
module pc_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int INC = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h180)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              exc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              jmp_taken,
   input  logic [ADDR_W-1:0] jmp_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next,
   output logic              pc_valid,
   output logic              redirect_pending,
   output logic              misalign_err
);
   typedef enum logic [1:0] {RESET, RUN, HOLD, HOLD_PEND} stateT;
   stateT state, stateNext;
   logic [1:0] pendLvl, pendLvlNext, incLvl;
   logic [ADDR_W-1:0] pendTgt, pendTgtNext, incRaw, incTgt;
   logic pend, running, incWins;
   always_comb begin
      incLvl = exc ? 2'd3 : br_taken ? 2'd2 : jmp_taken ? 2'd1 : 2'd0;
      incRaw = exc ? EXC_VEC : br_taken ? br_target : jmp_target;
`ifdef PC_ALIGN_CHECK_EN
      incTgt = {incRaw[ADDR_W-1:2], 2'b00};
`else
      incTgt = incRaw;
`endif
      pend = state == HOLD_PEND;
      running = state != RESET;
      // a newer request of equal level replaces the buffered one
      incWins = incLvl != 2'd0 && (!pend || incLvl >= pendLvl);
      pc_next = (!running || stall) ? pc : incWins ? incTgt : pend ? pendTgt : pc + ADDR_W'(INC);
      stateNext = (!running || !stall) ? RUN : (pend || incWins) ? HOLD_PEND : HOLD;
      pendLvlNext = (running && stall) ? (incWins ? incLvl : pendLvl) : 2'd0;
      pendTgtNext = (running && stall && incWins) ? incTgt : pendTgt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET;
         pc <= RESET_VEC;
         pendLvl <= 2'd0;
         pendTgt <= '0;
      end else begin
         state <= stateNext;
         pc <= pc_next;
         pendLvl <= pendLvlNext;
         pendTgt <= pendTgtNext;
      end
   end
   assign pc_valid = running;
   assign redirect_pending = pend;
`ifdef PC_ALIGN_CHECK_EN
   logic misalign;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else if (running && incWins && incRaw[1:0] != 2'b00) misalign <= 1'b1;
   end
   assign misalign_err = misalign;
`else
   assign misalign_err = 1'b0;
`endif
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and next-fetch-address unit for the instruction-fetch stage of the MIPS32 pipeline. It replaces the free-running PC register plus PC+4 adder pair. It adds reset vectoring, stall hold, prioritised branch/jump/exception redirects, and buffering of redirects that arrive while fetch is stalled. It drives the instruction-memory address and the IF/ID pipeline register.

## Interface
Parameters:
- `ADDR_W`, 32, PC width in bits.
- `INC`, 4, sequential increment in bytes.
- `RESET_VEC`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VEC`, 32'h0000_0180, exception handler address.

Ports:
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `stall`, in, 1, hold PC; from the hazard unit.
- `exc`, in, 1, exception redirect request.
- `br_taken`, in, 1, branch redirect request (from EX).
- `br_target`, in, ADDR_W, branch target.
- `jmp_taken`, in, 1, jump redirect request (from ID).
- `jmp_target`, in, ADDR_W, jump target.
- `pc`, out, ADDR_W, current fetch address (registered).
- `pc_next`, out, ADDR_W, value `pc` takes at the next edge (combinational).
- `pc_valid`, out, 1, `pc` is a valid fetch address (registered).
- `redirect_pending`, out, 1, a redirect is buffered during a stall (registered).
- `misalign_err`, out, 1, sticky misaligned-target flag (see Configuration).

## Operation
- Redirect priority: `exc` (level 3) > `br_taken` (level 2) > `jmp_taken` (level 1) > none (0). The highest active input forms the "incoming request": its level and target (EXC_VEC, br_target, jmp_target).
- States: RESET, RUN, HOLD (stall, nothing pending), HOLD_PEND (stall with a buffered redirect). Internal pending register holds level (2 bits) and target.
- RESET → RUN: on the first edge after `rst_n` rises. `pc` stays RESET_VEC and `pc_valid` goes 1, so RESET_VEC is fetched.
- RUN, no stall:
  - If an incoming request exists, `pc` ← its target.
  - Otherwise `pc` ← `pc + INC`, modulo 2^ADDR_W. Wrap from 32'hFFFF_FFFC to 0 is silent.
- Stall asserted, from RUN or HOLD:
  - `pc` holds.
  - An incoming request is captured into pending; go to HOLD_PEND.
  - With no request, go to HOLD.
- HOLD_PEND, stall still asserted:
  - An incoming request with level ≥ pending level overwrites pending, so a newer same-level request wins.
  - A lower-level request is dropped.
- Stall released with a redirect pending: compare the incoming request against pending using the same ≥ rule.
  - `pc` ← the winner's target.
  - Pending clears and `redirect_pending` ← 0; go to RUN.
- Stall released from HOLD: same as RUN.
- `pc_next` always equals the value loaded at the next edge, including hold (`pc_next` = `pc`) and pending resolution.
- `pc_valid` stays 1 in every state except RESET.

## Timing
- Reset values: `pc` = RESET_VEC, `pc_valid` = 0, `redirect_pending` = 0, `misalign_err` = 0, pending level = 0.
- Reset is asynchronous: asserting `rst_n` mid-stall or mid-pending discards the buffered redirect immediately.
- Redirect latency is one cycle: a request sampled at edge N appears on `pc` after edge N.
- Stall is honoured at the same edge it is sampled; `pc` never advances on a sampled stall.
- `redirect_pending` rises at the edge that captures a request during stall. It falls at the edge where stall is sampled low.
- `pc_next` is combinational from `pc`, the inputs and pending state. It has no path from `pc_next` back to the inputs.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - Any redirect target whose low two bits are non-zero sets `misalign_err`, at the edge it is loaded or captured into pending.
  - `misalign_err` stays 1 until reset.
  - The target's low two bits are forced to 0 before loading.
- Undefined:
  - `misalign_err` is tied to 0.
  - Targets are loaded verbatim.

## Test plan
- Reset then 4 free cycles: `pc_valid` is 0 during reset. After release, `pc` reads 0x0 (valid), 0x4, 0x8, 0xC.
- `br_taken`=1, `br_target`=0x100 together with `jmp_taken`=1, `jmp_target`=0x200 → next `pc` = 0x100. `exc` plus both → `pc` = 0x180.
- Stall for 3 cycles with `jmp_taken`/0x40 in cycle 1 and `br_taken`/0x80 in cycle 2 → `pc` holds, `redirect_pending`=1. On release `pc` = 0x80 and `redirect_pending`=0.
- Stall with a pending branch to 0x80; a jump to 0x40 arrives on the release cycle → `pc` = 0x80. An `exc` arriving on the release cycle instead → `pc` = 0x180.
- `RESET_VEC`=32'hFFFF_FFF8: run 3 cycles → `pc` reads 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- With `PC_ALIGN_CHECK_EN` defined, `br_target`=0x102 → `pc` = 0x100 and `misalign_err` = 1, sticky until `rst_n` is asserted low. Without the macro → `pc` = 0x102 and `misalign_err` = 0.
